// File: rtl/temp_spi_reader_pkg.sv
// rtl/temp_spi_reader_pkg.sv - shared types and constants for the temperature sensor SPI reader
package temp_spi_pkg;
   localparam int NUM_SENS = 3;
   localparam int TEMP_W   = 16;

   localparam logic [TEMP_W-1:0] FAULT_OPEN  = 16'hFFFF;
   localparam logic [TEMP_W-1:0] FAULT_SHORT = 16'h0000;

   // Transaction engine states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_SCK_HI,
      ST_SCK_LO,
      ST_CS_HOLD,
      ST_GAP
   } state_t;

   // Sweep sequencer states
   typedef enum logic [1:0] {
      SW_IDLE,
      SW_XFER,
      SW_GAP
   } sweep_t;

   function automatic logic is_fault_code(input logic [TEMP_W-1:0] v);
      return (v == FAULT_OPEN) || (v == FAULT_SHORT);
   endfunction
endpackage

// File: rtl/temp_spi_reader_if.sv
// rtl/temp_spi_reader_if.sv - shared SCK / data line and the three chip selects
interface temp_spi_reader_if;
   logic temp_sck;
   logic temp1_csn;
   logic temp2_csn;
   logic temp3_csn;
   logic temp_so;

   modport master (
      output temp_sck, temp1_csn, temp2_csn, temp3_csn,
      input  temp_so
   );

   modport slave (
      input  temp_sck, temp1_csn, temp2_csn, temp3_csn,
      output temp_so
   );
endinterface

// File: rtl/temp_spi_reader_xfer.sv
// rtl/temp_spi_reader_xfer.sv - single 16-bit read: CS setup, 16 SCK periods, CS hold
module temp_spi_xfer
   import temp_spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              so,
   output logic              sck,
   output logic              done,
   output logic [TEMP_W-1:0] data,
   output logic [4:0]        count
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [4:0] NBITS = 5'(TEMP_W);

   state_t            state, state_nxt;
   logic [DW-1:0]     div_cnt;
   logic              div_last;
   logic [TEMP_W-1:0] shift;
   logic [4:0]        bit_cnt;

   assign div_last = (div_cnt == DW'(CLK_DIV - 1));
   assign sck      = (state == ST_SCK_HI);
   assign data     = shift;
   assign count    = bit_cnt;

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         ST_IDLE:     if (start) state_nxt = ST_CS_SETUP;
         ST_CS_SETUP: if (div_last) state_nxt = ST_SCK_HI;
         ST_SCK_HI:   if (div_last) state_nxt = ST_SCK_LO;
         ST_SCK_LO:   if (div_last) state_nxt = (bit_cnt < NBITS) ? ST_SCK_HI : ST_CS_HOLD;
         ST_CS_HOLD: begin
            if (div_last) begin
               state_nxt = ST_IDLE;
               done      = 1'b1;
            end
         end
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         shift   <= '0;
         bit_cnt <= '0;
      end else begin
         state <= state_nxt;
         // Divider restarts on every phase change so each phase lasts CLK_DIV cycles
         if (state != state_nxt || state == ST_IDLE)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + DW'(1);

         if (state == ST_SCK_HI && div_cnt == '0) begin
            shift   <= {shift[TEMP_W-2:0], so};
            bit_cnt <= bit_cnt + 5'd1;
         end else if (done) begin
            bit_cnt <= '0;
         end
      end
   end
endmodule

// File: rtl/temp_spi_reader.sv
// rtl/temp_spi_reader.sv - round-robin reader for three SPI temperature sensors
// Optional TEMP_SPI_FAULT_EN rejects 16'hFFFF / 16'h0000 readings and flags them in temp_fault.
module temp_spi_reader
   import temp_spi_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int SWEEP_CYCLES = 1600000,
   parameter int CS_GAP       = 8
) (
   input  logic                fab_clk_16MHz,
   input  logic                rst_n,
   input  logic                en,
   temp_spi_reader_if.master   spi,
   output logic [TEMP_W-1:0]   temp1,
   output logic [TEMP_W-1:0]   temp2,
   output logic [TEMP_W-1:0]   temp3,
   output logic                temp_valid,
   output logic [4:0]          temp_count_data,
   output logic                busy,
   output logic [NUM_SENS-1:0] temp_fault
);
   localparam int TW = (SWEEP_CYCLES > 1) ? $clog2(SWEEP_CYCLES) : 1;
   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   sweep_t            sw, sw_nxt;
   logic [TW-1:0]     timer;
   logic              tick;
   logic              pending;
   logic              pend_clr;
   logic [GW-1:0]     gap_cnt;
   logic              gap_last;
   logic [1:0]        idx, idx_nxt;
   logic [2:0]        csn_q;
   logic              valid_nxt;
   logic              xfer_start;
   logic              xfer_done;
   logic [TEMP_W-1:0] xfer_data;
   logic [TEMP_W-1:0] result [NUM_SENS];

   temp_spi_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
      .clk   (fab_clk_16MHz),
      .rst_n (rst_n),
      .start (xfer_start),
      .so    (spi.temp_so),
      .sck   (spi.temp_sck),
      .done  (xfer_done),
      .data  (xfer_data),
      .count (temp_count_data)
   );

   assign tick     = (timer == '0);
   assign gap_last = (gap_cnt == GW'(CS_GAP - 1));
   assign busy     = (sw != SW_IDLE);

   assign spi.temp1_csn = csn_q[0];
   assign spi.temp2_csn = csn_q[1];
   assign spi.temp3_csn = csn_q[2];

   assign temp1 = result[0];
   assign temp2 = result[1];
   assign temp3 = result[2];

   always_comb begin
      sw_nxt     = sw;
      idx_nxt    = idx;
      xfer_start = 1'b0;
      pend_clr   = 1'b0;
      valid_nxt  = 1'b0;
      case (sw)
         SW_IDLE: begin
            // A pending tick is consumed whether or not en allows the sweep
            if (pending) begin
               pend_clr = 1'b1;
               if (en) begin
                  sw_nxt     = SW_XFER;
                  idx_nxt    = 2'd0;
                  xfer_start = 1'b1;
               end
            end
         end
         SW_XFER: if (xfer_done) sw_nxt = SW_GAP;
         SW_GAP: begin
            if (gap_last) begin
               if (idx < 2'(NUM_SENS - 1)) begin
                  sw_nxt     = SW_XFER;
                  idx_nxt    = idx + 2'd1;
                  xfer_start = 1'b1;
               end else begin
                  sw_nxt    = SW_IDLE;
                  valid_nxt = 1'b1;
               end
            end
         end
         default: sw_nxt = SW_IDLE;
      endcase
   end

   always_ff @(posedge fab_clk_16MHz) begin
      if (!rst_n) begin
         sw         <= SW_IDLE;
         timer      <= '0;
         pending    <= 1'b0;
         gap_cnt    <= '0;
         idx        <= '0;
         csn_q      <= 3'b111;
         temp_valid <= 1'b0;
         for (int i = 0; i < NUM_SENS; i++) result[i] <= '0;
      end else begin
         sw         <= sw_nxt;
         idx        <= idx_nxt;
         temp_valid <= valid_nxt;
         timer      <= tick ? TW'(SWEEP_CYCLES - 1) : timer - TW'(1);

         if (tick)
            pending <= 1'b1;
         else if (pend_clr)
            pending <= 1'b0;

         gap_cnt <= (sw == SW_GAP) ? gap_cnt + GW'(1) : '0;

         if (xfer_start)
            csn_q <= ~(3'b001 << idx_nxt);
         else if (xfer_done)
            csn_q <= 3'b111;

         if (xfer_done) begin
`ifdef TEMP_SPI_FAULT_EN
            if (!is_fault_code(xfer_data))
               result[idx] <= xfer_data;
`else
            result[idx] <= xfer_data;
`endif
         end
      end
   end

`ifdef TEMP_SPI_FAULT_EN
   logic [NUM_SENS-1:0] fault_q;

   always_ff @(posedge fab_clk_16MHz) begin
      if (!rst_n)
         fault_q <= '0;
      else if (xfer_done)
         fault_q[idx] <= is_fault_code(xfer_data);
   end

   assign temp_fault = fault_q;
`else
   assign temp_fault = '0;
`endif
endmodule
